// File: rtl/cursor_ctrl_overlay.sv
// Keyboard-driven crosshair cursor: debounced-free key sync, tick-paced motion with
// wrap/clamp at screen edges, and a one-cycle pixel overlay using frame-latched coordinates.
module cursor_ctrl_overlay #(
    parameter int          H_LIMIT   = 640,
    parameter int          V_LIMIT   = 480,
    parameter int          VELOCITY  = 2,
    parameter int          LENGTH    = 5,
    parameter int          TICK_DIV  = 2097152,
    parameter int          WRAP_MODE = 1,
    parameter logic [23:0] COLOR     = 24'hFF00FF
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [3:0]  KEY,
    input  logic        cursor_en,
    input  logic        center_req,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic [7:0]  in_R,
    input  logic [7:0]  in_G,
    input  logic [7:0]  in_B,
    output logic [7:0]  out_R,
    output logic [7:0]  out_G,
    output logic [7:0]  out_B,
    output logic        out_valid,
    output logic [12:0] c_x,
    output logic [12:0] c_y
);

    localparam int                 CNT_W = $clog2(TICK_DIV);
    localparam logic signed [13:0] H_LIM = 14'(H_LIMIT);
    localparam logic signed [13:0] V_LIM = 14'(V_LIMIT);
    localparam logic signed [13:0] VEL   = 14'(VELOCITY);
    localparam logic signed [13:0] ARM   = 14'(LENGTH / 2);
    localparam logic [12:0]        X_CTR = 13'(H_LIMIT / 2);
    localparam logic [12:0]        Y_CTR = 13'(V_LIMIT / 2);

    // Bring an out-of-range signed coordinate back onto the screen.
    function automatic logic [12:0] fold(input logic signed [13:0] v, input logic signed [13:0] lim);
        logic signed [13:0] r;
        r = v;
        if (v < 0)
            r = (WRAP_MODE != 0) ? v + lim : 14'sd0;
        else if (v >= lim)
            r = (WRAP_MODE != 0) ? v - lim : lim - 14'sd1;
        return r[12:0];
    endfunction

    function automatic logic signed [13:0] abs14(input logic signed [13:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic [3:0]       key_s1, key_s2;
    logic             left, up, down, right;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [12:0]      x, y, dx, dy;
    logic [12:0]      x_next, y_next;
    logic signed [13:0] step_x, step_y, col_d, row_d;
    logic             hit_p0;

    assign left  = ~key_s2[3];
    assign up    = ~key_s2[2];
    assign down  = ~key_s2[1];
    assign right = ~key_s2[0];
    assign tick  = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign c_x   = x;
    assign c_y   = y;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            tick_cnt <= '0;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_comb begin
        step_x = '0;
        step_y = '0;
        if (left && !right)      step_x = -VEL;
        else if (right && !left) step_x = VEL;
        if (up && !down)         step_y = -VEL;
        else if (down && !up)    step_y = VEL;
        x_next = fold($signed({1'b0, x}) + step_x, H_LIM);
        y_next = fold($signed({1'b0, y}) + step_y, V_LIM);
    end

    // Display copies sample the pre-update position, so a coincident move shows next frame.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            x  <= X_CTR;
            y  <= Y_CTR;
            dx <= X_CTR;
            dy <= Y_CTR;
        end else begin
            if (center_req) begin
                x <= X_CTR;
                y <= Y_CTR;
            end else if (tick) begin
                x <= x_next;
                y <= y_next;
            end
            if (frame_start) begin
                dx <= x;
                dy <= y;
            end
        end
    end

    always_comb begin
        col_d  = $signed({1'b0, col}) - $signed({1'b0, dx});
        row_d  = $signed({1'b0, row}) - $signed({1'b0, dy});
        hit_p0 = ((row == dy) && (abs14(col_d) <= ARM)) ||
                 ((col == dx) && (abs14(row_d) <= ARM));
    end

    // Output register stage: one cycle from pixel in to pixel out.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            out_R     <= '0;
            out_G     <= '0;
            out_B     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= pix_valid;
            if (pix_valid && cursor_en && hit_p0) begin
                out_R <= COLOR[23:16];
                out_G <= COLOR[15:8];
                out_B <= COLOR[7:0];
            end else begin
                out_R <= in_R;
                out_G <= in_G;
                out_B <= in_B;
            end
        end
    end

endmodule
